// File: rtl/breadboard_pkg.sv
// Shared definitions for the Breadboard sweep stage.
//   state_t     : sweep controller states
//   NUM_VECTORS : number of input combinations driven per sweep
//   IDX_W       : width of the vector index
//   EXP_R*      : known-good minterm maps of the Breadboard block
package breadboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned IDX_W       = 4;

  localparam logic [15:0] EXP_R1 = 16'hF8A8;
  localparam logic [15:0] EXP_R3 = 16'hEAC0;
  localparam logic [15:0] EXP_R5 = 16'h111F;

endpackage

// File: rtl/breadboard_sweeper_timer.sv
// sweep_settle_timer: loadable down-counter that times the settle interval.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : reload value
//   dec        : decrement by one; holds at zero
//   value      : current count
//   zero       : count is zero
module sweep_settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && !zero) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper: clocked truth-table sweep around the Breadboard block.
// Drives all 16 {w,x,y,z} combinations in ascending order, holds each for
// SETTLE_CYCLES clocks, samples r1/r3/r5 in the last cycle of each vector and
// stores the results as three 16-bit minterm maps.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin a sweep (IDLE only) / terminate a sweep
//   w, x, y, z          : registered Breadboard drive (w = MSB of index)
//   r1, r3, r5          : Breadboard results
//   busy, done          : sweep in progress / one-cycle completion pulse
//   map_r1/r3/r5        : bit k = sampled output for input index k
//   rd_addr, rd_data    : combinational table read {r1, r3, r5}
module breadboard_sweeper
  import breadboard_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  input  logic        r1,
  input  logic        r3,
  input  logic        r5,
  output logic        busy,
  output logic        done,
  output logic [15:0] map_r1,
  output logic [15:0] map_r3,
  output logic [15:0] map_r5,
  input  logic [3:0]  rd_addr,
  output logic [2:0]  rd_data
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_zero;
  logic               tmr_load, tmr_dec;
  logic               clr_maps, sample, idx_inc, idx_clr;

  sweep_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort beats the sample in the same cycle; the index is cleared on the
  // last sample so the drive already reads zero during FINISH.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    clr_maps = 1'b0;
    sample   = 1'b0;
    idx_inc  = 1'b0;
    idx_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          clr_maps = 1'b1;
          idx_clr  = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          idx_clr = 1'b1;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          sample = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
            idx_clr = 1'b1;
          end else begin
            idx_inc  = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      map_r1 <= '0;
      map_r3 <= '0;
      map_r5 <= '0;
    end else begin
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + IDX_W'(1);

      if (clr_maps) begin
        map_r1 <= '0;
        map_r3 <= '0;
        map_r5 <= '0;
      end else if (sample) begin
        map_r1[idx_q] <= r1;
        map_r3[idx_q] <= r3;
        map_r5[idx_q] <= r5;
      end
    end
  end

  assign {w, x, y, z} = idx_q;
  assign busy         = (state_q == SETTLE);
  assign done         = (state_q == FINISH);
  assign rd_data      = {map_r1[rd_addr], map_r3[rd_addr], map_r5[rd_addr]};

  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SETTLE) |-> (tmr_value <= RELOAD));

endmodule

// File: tb/tb_breadboard_sweeper.sv
module tb_breadboard_sweeper;

  localparam logic [15:0] BB_R1 = 16'hF8A8;
  localparam logic [15:0] BB_R3 = 16'hEAC0;
  localparam logic [15:0] BB_R5 = 16'h111F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic        wa, xa, ya, za, wb, xb, yb, zb;
  logic        r1a, r3a, r5a, r1b, r3b, r5b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] m1a, m3a, m5a, m1b, m3b, m5b;
  logic [3:0]  rda_a, rda_b;
  logic [2:0]  rdd_a, rdd_b;

  // Breadboard model: a truth table per output, indexed by {w,x,y,z}
  logic [15:0] tt1, tt3, tt5;
  assign r1a = tt1[{wa, xa, ya, za}];
  assign r3a = tt3[{wa, xa, ya, za}];
  assign r5a = tt5[{wa, xa, ya, za}];
  assign r1b = tt1[{wb, xb, yb, zb}];
  assign r3b = tt3[{wb, xb, yb, zb}];
  assign r5b = tt5[{wb, xb, yb, zb}];

  breadboard_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .w(wa), .x(xa), .y(ya), .z(za), .r1(r1a), .r3(r3a), .r5(r5a),
    .busy(busy_a), .done(done_a), .map_r1(m1a), .map_r3(m3a), .map_r5(m5a),
    .rd_addr(rda_a), .rd_data(rdd_a)
  );

  breadboard_sweeper #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .w(wb), .x(xb), .y(yb), .z(zb), .r1(r1b), .r3(r3b), .r5(r5b),
    .busy(busy_b), .done(done_b), .map_r1(m1b), .map_r3(m3b), .map_r5(m5b),
    .rd_addr(rda_b), .rd_data(rdd_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_abort(input bit sel, input logic v);
    if (sel) abort_b = v; else abort_a = v;
  endtask

  task automatic obs(input bit sel, output logic b, output logic d, output logic [3:0] v);
    b = sel ? busy_b : busy_a;
    d = sel ? done_b : done_a;
    v = sel ? {wb, xb, yb, zb} : {wa, xa, ya, za};
  endtask

  task automatic obs_maps(input bit sel, output logic [15:0] o1, output logic [15:0] o3,
                          output logic [15:0] o5);
    o1 = sel ? m1b : m1a;
    o3 = sel ? m3b : m3a;
    o5 = sel ? m5b : m5a;
  endtask

  // One sweep from IDLE. abort_cyc > 0 asserts abort during that busy cycle
  // (cycle 1 = first cycle after start is taken); restart_cyc pulses start
  // while busy; abort_fin asserts abort during the done cycle.
  task automatic run_sweep(input bit sel, input int s, input int abort_cyc,
                           input bit abort_with_start, input int restart_cyc,
                           input bit abort_fin);
    int          total, nsamp;
    logic [15:0] mask, e1, e3, e5, o1, o3, o5;
    logic [3:0]  ev, v, a;
    logic        eb, ed, b, d;
    if (abort_cyc > 0) begin
      nsamp = (abort_cyc - 1) / s;
      total = abort_cyc + 3;
    end else begin
      nsamp = 16;
      total = 16 * s + 1;
    end
    mask = (nsamp >= 16) ? 16'hFFFF : 16'((32'd1 << nsamp) - 32'd1);
    e1 = tt1 & mask;
    e3 = tt3 & mask;
    e5 = tt5 & mask;

    @(negedge clk);
    set_start(sel, 1'b1);
    if (abort_with_start) set_abort(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    set_abort(sel, 1'b0);
    for (int c = 1; c <= total; c++) begin
      if (abort_cyc > 0 && c > abort_cyc) begin
        eb = 1'b0; ed = 1'b0; ev = 4'd0;
      end else if (c <= 16 * s) begin
        eb = 1'b1; ed = 1'b0; ev = 4'((c - 1) / s);
      end else begin
        eb = 1'b0; ed = 1'b1; ev = 4'd0;
      end
      obs(sel, b, d, v);
      check_eq($sformatf("busy[s%0d c%0d]", s, c), 32'(b), 32'(eb));
      check_eq($sformatf("done[s%0d c%0d]", s, c), 32'(d), 32'(ed));
      check_eq($sformatf("vec[s%0d c%0d]", s, c), 32'(v), 32'(ev));
      set_abort(sel, (c == abort_cyc) || (abort_fin && c == 16 * s + 1));
      set_start(sel, c == restart_cyc);
      @(negedge clk);
    end
    set_abort(sel, 1'b0);
    set_start(sel, 1'b0);

    obs_maps(sel, o1, o3, o5);
    check_eq($sformatf("map_r1[s%0d]", s), 32'(o1), 32'(e1));
    check_eq($sformatf("map_r3[s%0d]", s), 32'(o3), 32'(e3));
    check_eq($sformatf("map_r5[s%0d]", s), 32'(o5), 32'(e5));
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom_range(0, 15));
      if (sel) rda_b = a; else rda_a = a;
      #1;
      check_eq($sformatf("rd_data[%0d]", a), 32'(sel ? rdd_b : rdd_a),
               32'({e1[a], e3[a], e5[a]}));
      @(negedge clk);
    end
  endtask

  initial begin
    logic        b, d;
    logic [3:0]  v;
    logic [15:0] o1, o3, o5;

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    rda_a = 4'd0; rda_b = 4'd0;
    tt1 = BB_R1; tt3 = BB_R3; tt5 = BB_R5;

    repeat (3) @(negedge clk);
    obs(0, b, d, v);
    check_eq("reset_busy", 32'(b), 32'd0);
    check_eq("reset_done", 32'(d), 32'd0);
    check_eq("reset_vec", 32'(v), 32'd0);
    obs_maps(0, o1, o3, o5);
    check_eq("reset_maps", 32'(o1 | o3 | o5), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sweep of the real Breadboard
    run_sweep(0, 4, 0, 0, 0, 0);
    rda_a = 4'd12;
    #1;
    check_eq("rd_addr12", 32'(rdd_a), 32'(3'b101));
    repeat (5) @(negedge clk);
    obs_maps(0, o1, o3, o5);
    check_eq("idle_hold_r1", 32'(o1), 32'(BB_R1));

    // Start while busy is ignored
    run_sweep(0, 4, 0, 0, 20, 0);

    // Abort in the final settle cycle of idx 5
    run_sweep(0, 4, 24, 0, 0, 0);
    obs_maps(0, o1, o3, o5);
    check_eq("abort_r1", 32'(o1), 32'h0008);
    check_eq("abort_r3", 32'(o3), 32'h0000);
    check_eq("abort_r5", 32'(o5), 32'h001F);

    // Abort during FINISH does not suppress done; start beats abort in IDLE
    run_sweep(0, 4, 0, 1, 0, 1);

    // SETTLE_CYCLES = 1 build, twice (second start clears maps first)
    run_sweep(1, 1, 0, 0, 0, 0);
    run_sweep(1, 1, 0, 0, 0, 0);

    // Reset in the middle of a sweep (idx = 7)
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(negedge clk);
    obs(0, b, d, v);
    check_eq("pre_reset_idx", 32'(v), 32'd7);
    rst_n = 1'b0;
    #1;
    obs(0, b, d, v);
    check_eq("midrst_busy", 32'(b), 32'd0);
    check_eq("midrst_done", 32'(d), 32'd0);
    check_eq("midrst_vec", 32'(v), 32'd0);
    obs_maps(0, o1, o3, o5);
    check_eq("midrst_maps", 32'(o1 | o3 | o5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs(0, b, d, v);
    check_eq("post_rst_idle", 32'({b, d, v}), 32'd0);
    run_sweep(0, 4, 0, 0, 0, 0);

    // Randomized Breadboard tables and control scenarios
    for (int it = 0; it < 8; it++) begin
      bit sel;
      int s, ac, rc;
      bit aws, af;
      tt1 = 16'($urandom);
      tt3 = 16'($urandom);
      tt5 = 16'($urandom);
      sel = 1'($urandom_range(0, 1));
      s   = sel ? 1 : 4;
      ac  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16 * s)) : 0;
      rc  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16 * s)) : 0;
      if (ac > 0 && rc >= ac) rc = 0;
      aws = 1'($urandom_range(0, 1));
      af  = (ac == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_sweep(sel, s, ac, aws, rc, af);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
